rf_dump_reader: RTL and testbench
=================================

# rf_dump_reader

Debug reader for the CPU register file. It walks a range of registers through the register file's dedicated debug read port (ra2/rd2). Each 32-bit value goes out as ASCII: eight lowercase hex digits, MSB first, then a newline (0x0A). Output is a ready/valid byte stream that feeds the board's UART transmitter / PDU console, so the register state can be inspected without halting the datapath's read ports.

## Interface
Parameters:
- NREG, 32, number of registers; address width is fixed at 5 bits, and address arithmetic is modulo 32.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk, input, 1, the single clock; all state updates on its rising edge.
  - rstn, input, 1, asynchronous active-low reset.
- Control:
  - start, input, 1, one-cycle request; sampled only in IDLE.
  - first_addr, input, 5, first register to dump; sampled on accepted start.
  - last_addr, input, 5, last register to dump (inclusive); sampled on accepted start.
  - busy, output, 1, high from the cycle after accepted start until the done cycle inclusive.
  - done, output, 1, one-cycle pulse after the final newline is accepted.
- Register file debug port:
  - dbg_ra, output, 5, registered read address to the register file debug port.
  - dbg_rd, input, 32, asynchronous read data from that port.
- Byte stream:
  - tx_data, output, 8, ASCII byte.
  - tx_valid, output, 1, byte valid.
  - tx_ready, input, 1, sink accepts when tx_valid && tx_ready.

## Operation
- FSM states:
  - IDLE
  - FETCH
  - SEND_HEX
  - SEND_NL
  - DONE
- IDLE:
  - On start: latch last_addr, set dbg_ra <= first_addr, go to FETCH.
  - Otherwise hold dbg_ra.
- FETCH, one cycle:
  - shift <= dbg_rd, nib <= 0, go to SEND_HEX.
  - The snapshot is taken here, so later writes to that register do not tear the line.
  - The debug port does not bypass writes, so a write landing in this same cycle shows the old value.
- SEND_HEX:
  - tx_data = ascii(shift[31:28]): 0–9 maps to 0x30+n, 10–15 maps to 0x61+(n−10).
  - On accept: shift <<= 4 and nib++.
  - After the 8th accept, go to SEND_NL.
- SEND_NL:
  - tx_data = 0x0A.
  - On accept: if dbg_ra == latched last, go to DONE; else dbg_ra <= dbg_ra+1 (5-bit wrap, 31→0) and go to FETCH.
- DONE, one cycle:
  - done = 1, then IDLE.
- Register count is (last − first) mod 32 + 1.
  - first == last gives exactly one register.
  - first > last wraps through 31→0.
  - first = 0, last = 31 dumps all 32.
- start while busy (any state other than IDLE) is ignored entirely. No queuing.
- Stream rule: while tx_valid && !tx_ready, tx_data must stay stable and tx_valid must stay high.
- Reset values:
  - state = IDLE, dbg_ra = 0, busy = 0, done = 0.
  - tx_valid = 0, tx_data = 0x00, shift = 0, nib = 0.
- Reset mid-dump: return to the reset values immediately (asynchronous). The partial line is abandoned; no newline is emitted.

## Timing
- Cycle 0: start high in IDLE.
- Cycle 1: FETCH, dbg_ra = first_addr, busy = 1.
- Cycle 2: first hex byte valid. Outputs (tx_data, tx_valid, busy, done, dbg_ra) are registered.
- With tx_ready held high, one byte per cycle, so 9 cycles per register plus 1 FETCH cycle: 10 cycles per register.
- tx_valid is low during FETCH (one bubble between lines).
- N registers with no backpressure:
  - The last newline is accepted at cycle 10N.
  - done = 1 at cycle 10N+1.
  - IDLE at cycle 10N+2.
  - The earliest next start is accepted at cycle 10N+2.
- Backpressure stretches each byte by the number of stalled cycles. There is no other latency change.

## Structure
- Shared package (`debug_pkg`):
  - FSM state encoding (localparam).
  - ASCII constants: 0x30 '0', 0x61 'a', 0x0A newline.
  - REG_ADDR_W = 5.
- One natural sub-module, `hex_ascii`: combinational 4-bit to 8-bit ASCII converter. It is reused by the planned memory-dump reader.
- Everything else (FSM, nibble counter, shift register, address counter) lives in `rf_dump_reader`.

## Test plan
- Reset values: assert rstn = 0 asynchronously mid-cycle → all outputs take their reset values (dbg_ra = 0, tx_valid = 0, busy = 0, done = 0) without waiting for a clock edge.
- Single register, no stall: reg2 = 0x2ffc, first = last = 2, tx_ready = 1 → bytes "00002ffc" then 0x0A on cycles 2–10, done at cycle 11, busy low at cycle 12.
- Two registers: regs 2..3 (0x2ffc, 0x1800) → 18 bytes "00002ffc\n00001800\n", tx_valid low at cycle 11 (FETCH), done at cycle 21.
- Backpressure and wrap: first = 31, last = 0, reg31 = 0xdeadbeef, tx_ready toggling 1-0-0 → output "deadbeef\n00000000\n"; each byte held stable across stalls; dbg_ra sequence is 31 then 0.
- Start while busy, and snapshot: pulse start with first = 5 mid-dump → ignored, stream unchanged. Write reg2 = 0x12345678 while its line is being sent → the old value completes intact.
- Reset mid-dump: deassert rstn after 4 bytes of a dump → tx_valid = 0 and busy = 0 immediately, no newline emitted. A fresh start afterwards dumps correctly from cycle 2.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the debug dump readers: state encoding, address width
// and the ASCII constants used when formatting register values.
package debug_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NIBBLES    = DATA_W / 4;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h61;
    localparam logic [7:0] ASCII_NL   = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_SEND_HEX = 3'd2,
        ST_SEND_NL  = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/hex_ascii.sv
// Combinational 4-bit to lowercase ASCII hex digit converter.
module hex_ascii
    import debug_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        if (nib_i < 4'd10) begin
            ascii_o = ASCII_ZERO + {4'd0, nib_i};
        end else begin
            ascii_o = ASCII_A + {4'd0, nib_i} - 8'd10;
        end
    end

endmodule

// File: rtl/rf_dump_reader.sv
// Walks a register range through the register file debug port and streams each
// value as eight lowercase hex digits plus a newline.
module rf_dump_reader
    import debug_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [REG_ADDR_W-1:0] first_addr,
    input  logic [REG_ADDR_W-1:0] last_addr,
    output logic                  busy,
    output logic                  done,
    output logic [REG_ADDR_W-1:0] dbg_ra,
    input  logic [DATA_W-1:0]     dbg_rd,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [2:0]            dbg_state
);

    // Byte stream: a byte transfers on a rising edge where tx_valid && tx_ready;
    // once tx_valid is raised, tx_data and tx_valid hold until that transfer.
    state_t                state_q, state_d;
    logic [REG_ADDR_W-1:0] ra_q, ra_d;
    logic [REG_ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [2:0]            nib_q, nib_d;
    logic [7:0]            hex_byte;
    logic                  accept;
    logic [REG_ADDR_W-1:0] ra_next;

    hex_ascii u_hex_ascii (
        .nib_i   (shift_q[DATA_W-1 -: 4]),
        .ascii_o (hex_byte)
    );

    assign ra_next = (ra_q == REG_ADDR_W'(NREG - 1)) ? '0 : ra_q + 1'b1;
    assign accept  = tx_valid && tx_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            last_q  <= '0;
            shift_q <= '0;
            nib_q   <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            last_q  <= last_d;
            shift_q <= shift_d;
            nib_q   <= nib_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        last_d  = last_q;
        shift_d = shift_q;
        nib_d   = nib_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    last_d  = last_addr;
                    ra_d    = first_addr;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Snapshot the whole word so later writes cannot tear the line.
                shift_d = dbg_rd;
                nib_d   = '0;
                state_d = ST_SEND_HEX;
            end
            ST_SEND_HEX: begin
                if (accept) begin
                    shift_d = {shift_q[DATA_W-5:0], 4'h0};
                    nib_d   = nib_q + 1'b1;
                    if (nib_q == 3'(NIBBLES - 1)) begin
                        state_d = ST_SEND_NL;
                    end
                end
            end
            ST_SEND_NL: begin
                if (accept) begin
                    if (ra_q == last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        ra_d    = ra_next;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode straight from registered state, so they carry no input paths.
    always_comb begin
        tx_valid = (state_q == ST_SEND_HEX) || (state_q == ST_SEND_NL);
        tx_data  = 8'h00;
        if (state_q == ST_SEND_HEX) begin
            tx_data = hex_byte;
        end else if (state_q == ST_SEND_NL) begin
            tx_data = ASCII_NL;
        end
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        dbg_ra    = ra_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed, table-driven bench for rf_dump_reader with a register file model
// behind the debug port and a byte scoreboard on the output stream.
module tb_rf_dump_reader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic        busy;
    logic        done;
    logic [4:0]  dbg_ra;
    logic [31:0] dbg_rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  dbg_state;

    logic [31:0] rf [32];
    logic [7:0]  exp_q[$];
    int          total = 0;
    int          bad   = 0;

    typedef struct {
        logic [4:0]  first;
        logic [4:0]  last;
        int          mode;      // 0: tx_ready always high, 1: ready pattern 1-0-0
        int          poke_cyc;  // cycle of an extra start pulse, 0 = none
        int          wr_cyc;    // cycle of a register file write, 0 = none
        logic [4:0]  wr_addr;
        logic [31:0] wr_val;
        int          exp_done;  // expected done cycle, 0 = not checked
    } vec_t;

    vec_t vecs[7];

    rf_dump_reader #(.NREG(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .busy       (busy),
        .done       (done),
        .dbg_ra     (dbg_ra),
        .dbg_rd     (dbg_rd),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .dbg_state  (dbg_state)
    );

    assign dbg_rd = rf[dbg_ra];

    // Clock and global watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        string digits;
        digits = "0123456789abcdef";
        return digits.getc(int'(n));
    endfunction

    task automatic push_line(input logic [31:0] v);
        for (int i = 7; i >= 0; i--) exp_q.push_back(hex_char(v[i*4 +: 4]));
        exp_q.push_back(8'h0a);
    endtask

    // Driver + scoreboard for one dump; called at a negedge with the DUT idle.
    task automatic run_dump(input vec_t v);
        logic [4:0] span;
        logic [4:0] a;
        logic [4:0] exp_ra;
        logic [7:0] exp_b;
        logic [7:0] prev_data;
        logic       prev_stall;
        logic       last_was_nl;
        int         n;
        int         cyc;
        int         line;
        int         done_cyc;

        exp_q.delete();
        span = v.last - v.first;
        n = int'(span) + 1;
        for (int i = 0; i < n; i++) begin
            a = v.first + 5'(i);
            push_line(rf[a]);
        end

        first_addr = v.first;
        last_addr  = v.last;
        start      = 1'b1;
        tx_ready   = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        first_addr = ~v.first;
        last_addr  = ~v.last;
        cyc = 1;
        #1;
        check("fetch_busy", busy, 1);
        check("fetch_ra", dbg_ra, v.first);
        check("fetch_valid", tx_valid, 0);

        done_cyc = 0;
        line = 0;
        prev_stall = 1'b0;
        prev_data = 8'h00;
        last_was_nl = 1'b0;
        while (cyc < 3000) begin
            tx_ready = (v.mode == 0) ? 1'b1 : (cyc % 3 == 2);
            if (cyc == v.poke_cyc) begin
                start = 1'b1;
                first_addr = 5'd5;
                last_addr = 5'd5;
            end else begin
                start = 1'b0;
            end
            if (cyc == v.wr_cyc) rf[v.wr_addr] = v.wr_val;
            #1;
            if (prev_stall) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, prev_data);
            end
            if (last_was_nl) check("fetch_bubble", tx_valid, 0);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            last_was_nl = 1'b0;
            if (tx_valid) begin
                exp_ra = v.first + 5'(line);
                check("dbg_ra", dbg_ra, exp_ra);
                if (tx_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_byte: got %h expected no byte", tx_data);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("byte", tx_data, exp_b);
                        if (exp_b == 8'h0a) begin
                            line++;
                            last_was_nl = 1'b1;
                        end
                    end
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data = tx_data;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (done_cyc == 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done expected done within 3000 cycles");
        end
        check("bytes_left", exp_q.size(), 0);
        if (v.exp_done != 0) check("done_cycle", done_cyc, v.exp_done);
        @(negedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
    endtask

    initial begin
        rstn = 1'b0;
        start = 1'b0;
        tx_ready = 1'b0;
        first_addr = '0;
        last_addr = '0;
        for (int i = 0; i < 32; i++) rf[i] = (32'h01010101 * i) ^ 32'ha5a50000;
        rf[0]  = 32'h0000_0000;
        rf[2]  = 32'h0000_2ffc;
        rf[3]  = 32'h0000_1800;
        rf[31] = 32'hdead_beef;

        vecs[0] = '{5'd2,  5'd2, 0, 0, 0, 5'd0, 32'h0, 11};
        vecs[1] = '{5'd2,  5'd3, 0, 0, 0, 5'd0, 32'h0, 21};
        vecs[2] = '{5'd31, 5'd0, 1, 0, 0, 5'd0, 32'h0, 0};
        vecs[3] = '{5'd2,  5'd3, 0, 6, 4, 5'd2, 32'h1234_5678, 21};
        vecs[4] = '{5'd2,  5'd2, 0, 0, 0, 5'd0, 32'h0, 11};
        vecs[5] = '{5'd0,  5'd31, 0, 0, 0, 5'd0, 32'h0, 321};
        vecs[6] = '{5'd30, 5'd1, 1, 0, 0, 5'd0, 32'h0, 0};

        #12;
        check("rst_ra", dbg_ra, 0);
        check("rst_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", tx_data, 0);
        check("rst_state", dbg_state, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) run_dump(vecs[k]);

        // Asynchronous reset in the middle of a line.
        first_addr = 5'd2;
        last_addr = 5'd3;
        start = 1'b1;
        tx_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("pre_rst_valid", tx_valid, 1);
        check("pre_rst_busy", busy, 1);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ra", dbg_ra, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_data", tx_data, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_nl", tx_valid, 0);
        end
        rstn = 1'b1;
        @(negedge clk);
        run_dump(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
